// File: rtl/life_pkg.sv
`timescale 1ns/1ps
// life_pkg: definitions shared by the Game-of-Life run controller.
//   - life_state_e : controller FSM state and its 2-bit encoding
//   - LIFE_PERIOD_W / LIFE_GEN_W : default widths of the period input and
//     the generation counter
//   - cell_idx()   : bit position of cell (row i, column j) in a board
//                    vector that is n columns wide
package life_pkg;

  localparam int LIFE_PERIOD_W = 32;
  localparam int LIFE_GEN_W    = 32;

  typedef enum logic [1:0] {
    LIFE_PAUSED   = 2'd0,
    LIFE_RUN_WAIT = 2'd1,
    LIFE_EVOLVE   = 2'd2,
    LIFE_STABLE   = 2'd3
  } life_state_e;

  // Boards are stored row-major with row i starting at bit i*n.
  function automatic int cell_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/life_period_timer.sv
`timescale 1ns/1ps
// life_period_timer: wait timer between generations in run mode.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the wait; timer goes to 0 and the period is captured
//   count    : advance the timer by one
//   period   : requested wait length in cycles; 0 behaves as 1
//   expire   : high while timer == max(period,1)-1 (the last wait cycle)
module life_period_timer
  import life_pkg::*;
#(
  parameter int P_PERIOD_W = LIFE_PERIOD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  count,
  input  logic [P_PERIOD_W-1:0] period,
  output logic                  expire
);

  localparam logic [P_PERIOD_W-1:0] ONE = 1;

  logic [P_PERIOD_W-1:0] timer_q;
  // Period is captured when the wait begins so that a change on the input
  // mid-wait does not shorten or stretch the wait already in progress.
  logic [P_PERIOD_W-1:0] period_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= '0;
      period_q <= ONE;
    end else if (clear) begin
      timer_q  <= '0;
      period_q <= (period == '0) ? ONE : period;
    end else if (count) begin
      timer_q  <= timer_q + ONE;
    end
  end

  assign expire = (timer_q == (period_q - ONE));

endmodule

// File: rtl/life_run_controller.sv
`timescale 1ns/1ps
// life_run_controller: owns the current Game-of-Life board and sequences the
// evolution unit, one generation at a time, either by single step or
// free-running with a programmable wait between generations.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_run/pause/step   one-cycle command pulses from the command decoder
//   load_valid/ready     board load handshake, load_data is the pattern
//   period               run-mode wait in cycles (0 treated as 1)
//   evo_prev, evo_start  board and one-cycle start pulse to evolution unit
//   evo_next, evo_done   result and its one-cycle valid pulse
//   board, gen_count     current generation and count since last load
//   state, stable        FSM state (debug visibility) and still-life flag
//
// Handshake: a load transfers on a cycle where load_valid && load_ready are
// both high; load_ready depends only on state (PAUSED or STABLE), never on
// load_valid, and the requester holds load_data stable while load_valid is
// high. evo_done is only honoured in EVOLVE; elsewhere it is dropped.
module life_run_controller
  import life_pkg::*;
#(
  parameter int P_PARAM_N  = 5,
  parameter int P_PARAM_M  = 5,
  parameter int P_PERIOD_W = LIFE_PERIOD_W,
  parameter int P_GEN_W    = LIFE_GEN_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_run,
  input  logic                           cmd_pause,
  input  logic                           cmd_step,
  input  logic                           load_valid,
  input  logic [P_PARAM_N*P_PARAM_M-1:0] load_data,
  output logic                           load_ready,
  input  logic [P_PERIOD_W-1:0]          period,
  output logic [P_PARAM_N*P_PARAM_M-1:0] evo_prev,
  output logic                           evo_start,
  input  logic [P_PARAM_N*P_PARAM_M-1:0] evo_next,
  input  logic                           evo_done,
  output logic [P_PARAM_N*P_PARAM_M-1:0] board,
  output logic [P_GEN_W-1:0]             gen_count,
  output logic [1:0]                     state,
  output logic                           stable
);

  localparam int W = P_PARAM_N * P_PARAM_M;

  localparam logic [1:0] S_PAUSED   = LIFE_PAUSED;
  localparam logic [1:0] S_RUN_WAIT = LIFE_RUN_WAIT;
  localparam logic [1:0] S_EVOLVE   = LIFE_EVOLVE;
  localparam logic [1:0] S_STABLE   = LIFE_STABLE;

  localparam logic [P_GEN_W-1:0] GEN_ONE = 1;

  logic [1:0]         state_q;
  logic [W-1:0]       board_q;
  logic [P_GEN_W-1:0] gen_q;
  logic               stable_q;
  logic               evo_start_q;
  logic               single_q;      // current generation came from cmd_step
  logic               pause_pend_q;  // cmd_pause seen while evolving

  logic do_load;
  logic do_step;
  logic do_run;
  logic commit;
  logic still;
  logic stop_after;
  logic timer_clear;
  logic timer_count;
  logic timer_expire;

  assign load_ready = (state_q == S_PAUSED) || (state_q == S_STABLE);

  always_comb begin
    do_load     = load_valid && load_ready;
    // PAUSED priority: load, then step, then run.
    do_step     = (state_q == S_PAUSED) && !do_load && cmd_step;
    do_run      = (state_q == S_PAUSED) && !do_load && !cmd_step && cmd_run;
    commit      = (state_q == S_EVOLVE) && evo_done;
    still       = (evo_next == board_q);
    // A pause arriving on the same cycle as the result still lets the
    // result commit, then stops.
    stop_after  = single_q || pause_pend_q || cmd_pause;
    timer_clear = do_run || (commit && !still && !stop_after);
    timer_count = (state_q == S_RUN_WAIT);
  end

  life_period_timer #(
    .P_PERIOD_W (P_PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .count  (timer_count),
    .period (period),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PAUSED;
      board_q      <= '0;
      gen_q        <= '0;
      stable_q     <= 1'b0;
      evo_start_q  <= 1'b0;
      single_q     <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      // evo_start is a pulse raised only on entry to EVOLVE.
      evo_start_q <= 1'b0;
      case (state_q)
        S_PAUSED: begin
          if (do_load) begin
            board_q  <= load_data;
            gen_q    <= '0;
            stable_q <= 1'b0;
          end else if (do_step) begin
            single_q    <= 1'b1;
            evo_start_q <= 1'b1;
            state_q     <= S_EVOLVE;
          end else if (do_run) begin
            single_q <= 1'b0;
            state_q  <= S_RUN_WAIT;
          end
        end
        S_RUN_WAIT: begin
          if (cmd_pause) begin
            state_q <= S_PAUSED;
          end else if (timer_expire) begin
            evo_start_q <= 1'b1;
            state_q     <= S_EVOLVE;
          end
        end
        S_EVOLVE: begin
          if (cmd_pause) begin
            pause_pend_q <= 1'b1;
          end
          if (commit) begin
            board_q      <= evo_next;
            if (gen_q != '1) begin
              gen_q <= gen_q + GEN_ONE;
            end
            single_q     <= 1'b0;
            pause_pend_q <= 1'b0;
            if (still) begin
              stable_q <= 1'b1;
              state_q  <= S_STABLE;
            end else if (stop_after) begin
              state_q  <= S_PAUSED;
            end else begin
              state_q  <= S_RUN_WAIT;
            end
          end
        end
        S_STABLE: begin
          if (do_load) begin
            board_q  <= load_data;
            gen_q    <= '0;
            stable_q <= 1'b0;
            state_q  <= S_PAUSED;
          end
        end
        default: state_q <= S_PAUSED;
      endcase
    end
  end

  assign evo_prev  = board_q;
  assign evo_start = evo_start_q;
  assign board     = board_q;
  assign gen_count = gen_q;
  assign state     = state_q;
  assign stable    = stable_q;

endmodule

// File: tb/tb_life_run_controller.sv
`timescale 1ns/1ps
module tb_life_run_controller;

  localparam int W = 25;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          cmd_run, cmd_pause, cmd_step;
  logic          load_valid, load_ready;
  logic [W-1:0]  load_data;
  logic [31:0]   period;
  logic [W-1:0]  evo_prev, evo_next, board;
  logic          evo_start, evo_done, stable;
  logic [31:0]   gen_count;
  logic [1:0]    state;

  life_run_controller dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_run    (cmd_run),
    .cmd_pause  (cmd_pause),
    .cmd_step   (cmd_step),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .period     (period),
    .evo_prev   (evo_prev),
    .evo_start  (evo_start),
    .evo_next   (evo_next),
    .evo_done   (evo_done),
    .board      (board),
    .gen_count  (gen_count),
    .state      (state),
    .stable     (stable)
  );

  // reference model state
  logic [W-1:0] m_board;
  int           m_gen;
  bit           m_stable;
  int           evo_lat;
  int           n_cmp;
  int           n_err;

  localparam logic [W-1:0] BLINK_V = (25'd1 << 7) | (25'd1 << 12) | (25'd1 << 17);
  localparam logic [W-1:0] BLINK_H = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
  localparam logic [W-1:0] BLOCK   = (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12);

  // Conway rule on a 5x5 board with dead cells beyond the edge.
  function automatic logic [W-1:0] life(input logic [W-1:0] b);
    logic [W-1:0] r;
    int cnt;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        cnt = 0;
        for (int di = -1; di <= 1; di++) begin
          for (int dj = -1; dj <= 1; dj++) begin
            if (!(di == 0 && dj == 0) && (i + di) >= 0 && (i + di) < 5 &&
                (j + dj) >= 0 && (j + dj) < 5) begin
              cnt += int'(b[(i + di) * 5 + (j + dj)]);
            end
          end
        end
        r[i * 5 + j] = (cnt == 3) || (b[i * 5 + j] && cnt == 2);
      end
    end
    return r;
  endfunction

  function automatic int max1(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  // behavioural evolution unit: answers each evo_start after evo_lat cycles
  logic [W-1:0] rsp_cap;
  int           rsp_lat;
  initial begin
    evo_done = 1'b0;
    evo_next = '0;
    forever begin
      @(posedge clk);
      #2;
      if (evo_start === 1'b1) begin
        rsp_cap = evo_prev;
        rsp_lat = evo_lat;
        repeat (rsp_lat) @(posedge clk);
        #2;
        evo_next = life(rsp_cap);
        evo_done = 1'b1;
        @(posedge clk);
        #2;
        evo_done = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input logic [1:0] exp_state);
    chk("board", board, m_board);
    chk("evo_prev", evo_prev, m_board);
    chk("gen_count", gen_count, m_gen);
    chk("stable", stable, m_stable);
    chk("state", state, exp_state);
  endtask

  task automatic chk_reset();
    chk("rst_state", state, 0);
    chk("rst_board", board, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_stable", stable, 0);
    chk("rst_evo_start", evo_start, 0);
    chk("rst_load_ready", load_ready, 1);
  endtask

  task automatic no_start(input string tag, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (evo_start) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!evo_start && n < 300) begin
      tick();
      n++;
    end
    chk("start_seen", evo_start, 1);
  endtask

  task automatic load(input logic [W-1:0] b);
    chk("load_ready", load_ready, 1);
    load_data  = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    m_board  = b;
    m_gen    = 0;
    m_stable = 1'b0;
    chk_model(2'd0);
  endtask

  // Applies one generation to the model; returns 1 if it was a still life.
  function automatic bit commit_model();
    logic [W-1:0] nxt;
    bit s;
    nxt = life(m_board);
    s = (nxt == m_board);
    m_board = nxt;
    m_gen++;
    if (s) m_stable = 1'b1;
    return s;
  endfunction

  task automatic step_gen(input int lat, input bit with_run);
    bit s;
    evo_lat  = lat;
    cmd_step = 1'b1;
    cmd_run  = with_run;
    tick();
    cmd_step = 1'b0;
    cmd_run  = 1'b0;
    chk("step_start", evo_start, 1);
    chk("step_state", state, 2);
    tick();
    chk("step_pulse", evo_start, 0);
    chk("step_hold", board, m_board);
    repeat (lat) tick();
    s = commit_model();
    chk_model(s ? 2'd3 : 2'd0);
    no_start("step_no_more", 6);
  endtask

  task automatic run_gens(input int p, input int lat, input int ngen, input bit pause_mid);
    int n;
    bit s;
    period  = 32'(p);
    evo_lat = lat;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int k = 1; k <= ngen; k++) begin
      wait_start(n);
      chk("run_gap", n, max1(p));
      tick();
      if (pause_mid && k == ngen) cmd_pause = 1'b1;
      chk("run_pulse", evo_start, 0);
      chk("run_hold", board, m_board);
      tick();
      cmd_pause = 1'b0;
      repeat (lat - 1) tick();
      s = commit_model();
      if (s) begin
        chk_model(2'd3);
        no_start("stable_no_start", 8);
        return;
      end
      if (pause_mid && k == ngen) begin
        chk_model(2'd0);
        no_start("pause_mid_no_start", 10);
        return;
      end
      chk_model(2'd1);
    end
    // now in the first wait cycle: a pause here stops immediately
    cmd_pause = 1'b1;
    tick();
    cmd_pause = 1'b0;
    chk_model(2'd0);
    no_start("pause_no_start", 10);
  endtask

  // directed sequence
  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    cmd_run = 0; cmd_pause = 0; cmd_step = 0;
    load_valid = 0; load_data = '0; period = 32'd3;
    evo_lat = 1;
    m_board = '0; m_gen = 0; m_stable = 0;
    tick(); tick();
    chk_reset();
    rst = 1'b0;
    tick();
    chk_reset();

    // load a blinker and single-step it
    load(BLINK_V);
    step_gen(3, 1'b0);
    chk("blinker_h", board, BLINK_H);

    // run with period 3, model latency 1 (start spacing 5)
    load(BLINK_V);
    run_gens(3, 1, 4, 1'b0);
    chk("blinker_after4", board, BLINK_V);

    // pause one cycle after a start
    run_gens(2, 3, 2, 1'b1);

    // still life: 2x2 block
    load(BLOCK);
    run_gens($urandom_range(0, 4), 1, 3, 1'b0);
    chk("block_gen", gen_count, 1);
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    cmd_pause = 1'b1; tick(); cmd_pause = 1'b0;
    no_start("stable_cmds_ignored", 8);
    chk_model(2'd3);
    load(BLINK_V);

    // all-zero board is a still life
    load('0);
    step_gen(1, 1'b0);

    // period 0: start every 3 cycles with latency 1
    load(BLINK_V);
    run_gens(0, 1, 3, 1'b0);

    // load wins over step in the same cycle
    load_data  = BLOCK;
    load_valid = 1'b1;
    cmd_step   = 1'b1;
    tick();
    load_valid = 1'b0;
    cmd_step   = 1'b0;
    m_board = BLOCK; m_gen = 0; m_stable = 0;
    chk_model(2'd0);
    no_start("load_beats_step", 6);

    // step wins over run in the same cycle: one generation, then PAUSED
    load(BLINK_V);
    step_gen(2, 1'b1);

    // randomized boards, periods, latencies and pause points
    for (int it = 0; it < 8; it++) begin
      load(25'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        step_gen($urandom_range(1, 4), 1'b0);
      end else begin
        run_gens($urandom_range(0, 4), $urandom_range(1, 4),
                 $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
    end

    // reset mid-EVOLVE, result arrives after reset
    if (state == 2'd3) load(BLINK_V);
    load(BLINK_V);
    evo_lat  = 4;
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    chk("rst_evolve_start", evo_start, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset();
    repeat (4) tick();
    chk_reset();
    chk("late_done_board", board, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/life_run_controller.md
Name: life_run_controller

Overview:
- Sequences the Game-of-Life evolution datapath and owns the current board register.
- Presents the board to the evolution unit and starts one generation at a time, either on demand (single step) or free-running at a programmable cycle period.
- Captures each result, counts generations and detects a still life.
- Sits between the UI/command decoder (run/pause/step/load) and the evolution unit; its board output feeds the display path.

Parameters:
- P_PARAM_N, 5, board columns.
- P_PARAM_M, 5, board rows; the board is P_PARAM_N*P_PARAM_M bits, cell (i,j) at bit i*P_PARAM_N+j.
- P_PERIOD_W, 32, width of the run-period input.
- P_GEN_W, 32, width of the generation counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_run  in  1  one-cycle pulse: enter free-running mode.
- cmd_pause  in  1  one-cycle pulse: stop after any in-flight generation.
- cmd_step  in  1  one-cycle pulse: evolve exactly one generation.
- load_valid  in  1  load request; accepted when load_valid && load_ready.
- load_data  in  N*M  board pattern to load.
- load_ready  out  1  high in PAUSED and STABLE.
- period  in  P_PERIOD_W  cycles between generations in run mode; sampled when each wait begins; 0 is treated as 1.
- evo_prev  out  N*M  board presented to the evolution unit; always equals board.
- evo_start  out  1  one-cycle pulse requesting a generation.
- evo_next  in  N*M  result from the evolution unit.
- evo_done  in  1  one-cycle pulse; evo_next is valid in the same cycle.
- board  out  N*M  current generation.
- gen_count  out  P_GEN_W  generations since last load; saturates at all-ones.
- state  out  2  encoded FSM state.
- stable  out  1  high once a generation produced no change.

Behaviour:
- Reset values: state=PAUSED, board=0, gen_count=0, stable=0, evo_start=0, load_ready=1, timer=0, single/pause_pending flags=0.
- States: PAUSED=0, RUN_WAIT=1, EVOLVE=2, STABLE=3.
- PAUSED:
  - Priority is load > step > run.
  - load: board<=load_data, gen_count<=0, stable<=0; stay in PAUSED.
  - cmd_step: set single=1, go to EVOLVE.
  - cmd_run: single=0, timer<=0, go to RUN_WAIT.
- RUN_WAIT:
  - timer increments each cycle.
  - When timer==max(period,1)-1, go to EVOLVE.
  - cmd_pause goes to PAUSED and wins over a same-cycle expiry.
  - cmd_run/cmd_step are ignored.
- EVOLVE:
  - evo_start=1 in the first EVOLVE cycle only.
  - board is held constant until evo_done.
  - cmd_pause sets pause_pending; cmd_run/cmd_step are ignored.
  - On evo_done:
    - board<=evo_next, gen_count<=gen_count+1 (saturating).
    - If evo_next==board, set stable<=1 and go to STABLE.
    - Else if single or pause_pending, go to PAUSED (clear both flags).
    - Else timer<=0 and go to RUN_WAIT.
- evo_done outside EVOLVE is ignored and must not change any register.
- Latency:
  - Step to evo_start is 1 cycle.
  - evo_done to board update is 1 cycle (registered).
  - In run mode, evo_done to the next evo_start is max(period,1)+1 cycles.
- STABLE:
  - board is frozen; cmd_run/cmd_step/cmd_pause are ignored.
  - A load behaves as in PAUSED and exits to PAUSED with stable cleared.
- An all-zero board is a still life: its first evolution enters STABLE.
- rst in any state, including mid-EVOLVE, restores reset values next cycle; a late evo_done after reset is ignored.
- Simultaneous cmd_pause and evo_done in EVOLVE: the result is committed, then PAUSED (or STABLE if unchanged).

Decomposition:
- Package life_pkg holds:
  - state enum (PAUSED, RUN_WAIT, EVOLVE, STABLE) with the 2-bit encoding above;
  - default widths P_PERIOD_W/P_GEN_W;
  - board-index helper constant/function i*N+j.
- One sub-module: life_period_timer (load/clear, count, expire=timer==max(period,1)-1), instantiated once.

Test Plan:
- Load and step:
  - Stimulus: reset; load a blinker (bits 7,12,17 on 5x5); cmd_step; model returns bits 11,12,13 three cycles after evo_start.
  - Required: exactly one evo_start pulse; gen_count=1; board=bits 11,12,13; state=PAUSED.
- Run with period 3:
  - Stimulus: load the blinker; cmd_run; model latency 1.
  - Required: evo_start pulses every 5 cycles (3+1+1); gen_count increments each time; board alternates between the two blinker phases.
- Pause mid-generation:
  - Stimulus: run; assert cmd_pause one cycle after evo_start.
  - Required: the generation completes (board updated, gen_count+1), then PAUSED; no further evo_start.
- Still life:
  - Stimulus: load a 2x2 block (bits 6,7,11,12); cmd_run; model returns the same pattern.
  - Required: stable=1; state=STABLE; gen_count=1; later cmd_run/cmd_step produce no evo_start; a load returns to PAUSED with stable=0 and gen_count=0.
- period=0 and priority:
  - Stimulus: period=0 in run mode; then load_valid and cmd_step in the same cycle while PAUSED.
  - Required: period=0 gives an evo_start every 3 cycles with latency-1 model; in the same-cycle case the load wins, gen_count=0, and no evo_start is issued.
- Reset mid-operation:
  - Stimulus: rst during EVOLVE; evo_done arrives 2 cycles later.
  - Required: all outputs at reset values; the late evo_done leaves board=0 and gen_count=0.
